// File: rtl/lt24_pixel_arbiter_if.sv
// Pixel-write bus between lt24_pixel_arbiter (master) and LT24Display (slave).
interface lt24_pixel_if;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;

    modport master (output xAddr, yAddr, pixelData, pixelWrite, input pixelReady);
    modport slave  (input xAddr, yAddr, pixelData, pixelWrite, output pixelReady);
endinterface

// File: rtl/lt24_pixel_arbiter.sv
// Arbitrates NUM_REQ rectangle pixel sources onto one LT24Display write port.
// Optional: define LT24_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module lt24_pixel_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned LCD_WIDTH  = 240,
    parameter int unsigned LCD_HEIGHT = 320
) (
    input  logic                   clock,
    input  logic                   resetApp_n,
    input  logic [NUM_REQ-1:0]     reqValid,
    input  logic [8*NUM_REQ-1:0]   reqX0,
    input  logic [8*NUM_REQ-1:0]   reqX1,
    input  logic [9*NUM_REQ-1:0]   reqY0,
    input  logic [9*NUM_REQ-1:0]   reqY1,
    input  logic [16*NUM_REQ-1:0]  srcData,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             srcX,
    output logic [8:0]             srcY,
    output logic [NUM_REQ-1:0]     reqDone,
    output logic                   reqErr,
    output logic                   busy,
    lt24_pixel_if.master           lcd
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, CHECK, FETCH, LATCH, WRITE, DONE} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d;
    logic [IDX_W-1:0]     idx_q, idx_d, win_idx;
    logic [7:0]           x0_q, x0_d, x1_q, x1_d, cx_q, cx_d, srcx_q, srcx_d, xa_q, xa_d;
    logic [8:0]           y0_q, y0_d, y1_q, y1_d, cy_q, cy_d, srcy_q, srcy_d, ya_q, ya_d;
    logic [15:0]          pd_q, pd_d;
    logic                 pw_q, pw_d, err_q, err_d, rerr_q, rerr_d, busy_q, busy_d;
`ifndef LT24_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]     ptr_q, ptr_d, cand;
`endif

    // Winner selection among pending requests.
    always_comb begin
        win_idx = '0;
`ifdef LT24_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (reqValid[i]) win_idx = IDX_W'(i);
        end
`else
        cand = '0;
        // Descending scan so the candidate nearest pointer+1 wins; the pointer itself is last.
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            if (reqValid[cand]) win_idx = cand;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!resetApp_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            idx_q   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            srcx_q  <= '0;
            srcy_q  <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            pd_q    <= '0;
            pw_q    <= 1'b0;
            err_q   <= 1'b0;
            rerr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifndef LT24_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            srcx_q  <= srcx_d;
            srcy_q  <= srcy_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            pd_q    <= pd_d;
            pw_q    <= pw_d;
            err_q   <= err_d;
            rerr_q  <= rerr_d;
            busy_q  <= busy_d;
`ifndef LT24_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        idx_d   = idx_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        srcx_d  = srcx_q;
        srcy_d  = srcy_q;
        xa_d    = xa_q;
        ya_d    = ya_q;
        pd_d    = pd_q;
        pw_d    = pw_q;
        err_d   = err_q;
        rerr_d  = 1'b0;
`ifndef LT24_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|reqValid) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    idx_d   = win_idx;
                    x0_d    = reqX0[32'(win_idx)*8 +: 8];
                    x1_d    = reqX1[32'(win_idx)*8 +: 8];
                    y0_d    = reqY0[32'(win_idx)*9 +: 9];
                    y1_d    = reqY1[32'(win_idx)*9 +: 9];
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((x1_q < x0_q) || (y1_q < y0_q) ||
                    (32'(x1_q) >= LCD_WIDTH) || (32'(y1_q) >= LCD_HEIGHT)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cx_d    = x0_q;
                    cy_d    = y0_q;
                    srcx_d  = x0_q;
                    srcy_d  = y0_q;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                pd_d    = srcData[32'(idx_q)*16 +: 16];
                xa_d    = cx_q;
                ya_d    = cy_q;
                pw_d    = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                if (lcd.pixelReady) begin
                    pw_d = 1'b0;
                    if (cx_q == x1_q && cy_q == y1_q) begin
                        state_d = DONE;
                    end else if (cx_q == x1_q) begin
                        cx_d    = x0_q;
                        cy_d    = 9'(cy_q + 9'd1);
                        srcx_d  = x0_q;
                        srcy_d  = 9'(cy_q + 9'd1);
                        state_d = FETCH;
                    end else begin
                        cx_d    = 8'(cx_q + 8'd1);
                        srcx_d  = 8'(cx_q + 8'd1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                done_d  = grant_q;
                rerr_d  = err_q;
`ifndef LT24_ARB_FIXED_PRIO_EN
                ptr_d   = idx_q;
`endif
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign grant          = grant_q;
    assign srcX           = srcx_q;
    assign srcY           = srcy_q;
    assign reqDone        = done_q;
    assign reqErr         = rerr_q;
    assign busy           = busy_q;
    assign lcd.xAddr      = xa_q;
    assign lcd.yAddr      = ya_q;
    assign lcd.pixelData  = pd_q;
    assign lcd.pixelWrite = pw_q;
endmodule

// File: tb/tb_lt24_pixel_arbiter.sv
// Scoreboard bench for lt24_pixel_arbiter: directed cases plus randomized rectangles.
module tb_lt24_pixel_arbiter;
    localparam int N = 2;
    localparam int W = 240;
    localparam int H = 320;

    typedef struct { int x; int y; logic [15:0] d; } px_t;
    typedef struct { int idx; bit err; } done_t;

    logic            clock = 1'b0;
    logic            resetApp_n;
    logic [N-1:0]    reqValid;
    logic [8*N-1:0]  reqX0, reqX1;
    logic [9*N-1:0]  reqY0, reqY1;
    logic [16*N-1:0] srcData;
    logic [N-1:0]    grant, reqDone;
    logic [7:0]      srcX;
    logic [8:0]      srcY;
    logic            reqErr, busy;

    lt24_pixel_if lcd_if();

    lt24_pixel_arbiter #(.NUM_REQ(N), .LCD_WIDTH(W), .LCD_HEIGHT(H)) dut (
        .clock(clock), .resetApp_n(resetApp_n), .reqValid(reqValid),
        .reqX0(reqX0), .reqX1(reqX1), .reqY0(reqY0), .reqY1(reqY1),
        .srcData(srcData), .grant(grant), .srcX(srcX), .srcY(srcY),
        .reqDone(reqDone), .reqErr(reqErr), .busy(busy), .lcd(lcd_if)
    );

    always #5 clock = ~clock;

    int  n_checks = 0, n_fail = 0, n_accept = 0;
    bit  const_mode = 1'b0;
    int  rdy_mode = 0;
    bit  ready_manual = 1'b1;
    int  model_ptr = 0;
    px_t   exp_px[$];
    done_t exp_done[$];
    int    exp_grant[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Pixel content each source returns for a coordinate.
    function automatic logic [15:0] pix_fn(input int i, input logic [7:0] x, input logic [8:0] y);
        if (const_mode && i == 0) return 16'hF800;
        return {y[6:0], x} ^ ((i == 0) ? 16'h5A5A : 16'h0000);
    endfunction

    // Expected winner when the requesters in pend contend.
    function automatic int model_winner(input logic [N-1:0] pend, input int ptr);
`ifdef LT24_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (pend[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return 0;
    endfunction

    // Sources: one cycle read latency.
    always @(posedge clock) begin
        for (int i = 0; i < N; i++) srcData[16*i +: 16] <= pix_fn(i, srcX, srcY);
    end

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       lcd_if.pixelReady = 1'b1;
            1:       lcd_if.pixelReady = ($urandom_range(0, 3) != 0);
            default: lcd_if.pixelReady = ready_manual;
        endcase
    end

    // Monitor / scoreboard.
    logic         prev_w = 1'b0, prev_r = 1'b0;
    logic [32:0]  prev_bus = '0;
    logic [N-1:0] prev_grant = '0;
    always @(negedge clock) begin
        if (!resetApp_n) begin
            prev_w = 1'b0; prev_r = 1'b0; prev_grant = '0;
        end else begin
            if (prev_w && !prev_r) begin
                check("hold_write", 64'(lcd_if.pixelWrite), 64'd1);
                check("hold_bus", 64'({lcd_if.xAddr, lcd_if.yAddr, lcd_if.pixelData}), 64'(prev_bus));
            end
            if (lcd_if.pixelWrite) check("busy_in_write", 64'(busy), 64'd1);
            if (lcd_if.pixelWrite && lcd_if.pixelReady) begin
                n_accept++;
                if (exp_px.size() == 0) fail_now("unexpected_write");
                else begin
                    px_t e;
                    e = exp_px.pop_front();
                    check("write_x", 64'(lcd_if.xAddr), 64'(e.x));
                    check("write_y", 64'(lcd_if.yAddr), 64'(e.y));
                    check("write_data", 64'(lcd_if.pixelData), 64'(e.d));
                end
            end
            if (grant != '0 && prev_grant == '0) begin
                check("grant_onehot", 64'($onehot(grant)), 64'd1);
                if (exp_grant.size() == 0) fail_now("unexpected_grant");
                else check("grant_idx", 64'(grant), 64'(1 << exp_grant.pop_front()));
            end
            if (reqDone != '0) begin
                if (exp_done.size() == 0) fail_now("unexpected_done");
                else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check("done_idx", 64'(reqDone), 64'(1 << d.idx));
                    check("done_err", 64'(reqErr), 64'(d.err));
                    check("done_busy", 64'(busy), 64'd0);
                end
            end
            prev_w = lcd_if.pixelWrite;
            prev_r = lcd_if.pixelReady;
            prev_bus = {lcd_if.xAddr, lcd_if.yAddr, lcd_if.pixelData};
            prev_grant = grant;
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_srcx"}, 64'(srcX), 64'd0);
        check({tag, "_srcy"}, 64'(srcY), 64'd0);
        check({tag, "_done"}, 64'(reqDone), 64'd0);
        check({tag, "_err"}, 64'(reqErr), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_xaddr"}, 64'(lcd_if.xAddr), 64'd0);
        check({tag, "_yaddr"}, 64'(lcd_if.yAddr), 64'd0);
        check({tag, "_data"}, 64'(lcd_if.pixelData), 64'd0);
        check({tag, "_write"}, 64'(lcd_if.pixelWrite), 64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clock); #1 resetApp_n = 1'b0;
        exp_px.delete(); exp_done.delete(); exp_grant.delete();
        @(posedge clock); #1 resetApp_n = 1'b1;
        model_ptr = 0;
        @(negedge clock);
        check_zero_outputs("reset");
    endtask

    task automatic set_rect(input int idx, input int x0, input int x1, input int y0, input int y1);
        reqX0[8*idx +: 8] = 8'(x0);
        reqX1[8*idx +: 8] = 8'(x1);
        reqY0[9*idx +: 9] = 9'(y0);
        reqY1[9*idx +: 9] = 9'(y1);
    endtask

    task automatic push_expect(input int idx, input int x0, input int x1, input int y0, input int y1);
        bit bad;
        bad = (x1 < x0) || (y1 < y0) || (x1 >= W) || (y1 >= H);
        exp_grant.push_back(idx);
        if (!bad)
            for (int y = y0; y <= y1; y++)
                for (int x = x0; x <= x1; x++)
                    exp_px.push_back('{x: x, y: y, d: pix_fn(idx, 8'(x), 9'(y))});
        exp_done.push_back('{idx: idx, err: bad});
        model_ptr = idx;
    endtask

    task automatic drain_check();
        repeat (3) @(negedge clock);
        check("drain_px", 64'(exp_px.size()), 64'd0);
        check("drain_done", 64'(exp_done.size()), 64'd0);
    endtask

    task automatic do_req(input int idx, input int x0, input int x1, input int y0, input int y1,
                          output int lat);
        bit got;
        int bound;
        bound = 24 * (x1 - x0 + 1) * (y1 - y0 + 1) + 100;
        if (bound < 100) bound = 100;
        push_expect(idx, x0, x1, y0, y1);
        set_rect(idx, x0, x1, y0, y1);
        reqValid[idx] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            if (grant[idx]) begin got = 1'b1; break; end
        end
        reqValid[idx] = 1'b0;
        // Coordinates are scrambled mid-transfer; the arbiter must ignore them.
        set_rect(idx, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
        lat = 0;
        if (!got) begin
            fail_now("grant_timeout");
            return;
        end
        got = 1'b0;
        for (int t = 0; t < bound; t++) begin
            @(negedge clock);
            lat++;
            if (reqDone[idx]) begin got = 1'b1; break; end
        end
        if (!got) fail_now("done_timeout");
        drain_check();
    endtask

    initial begin
        int lat, base, order[4];
        int cnt[N];
        bit got;
        resetApp_n = 1'b0;
        reqValid = '0;
        reqX0 = '0; reqX1 = '0; reqY0 = '0; reqY1 = '0;
        lcd_if.pixelReady = 1'b1;
        repeat (2) @(negedge clock);
        check_zero_outputs("por");
        @(posedge clock); #1 resetApp_n = 1'b1;

        // 1x1 rectangle, constant colour, 5-cycle grant-to-done.
        const_mode = 1'b1;
        do_req(0, 5, 5, 7, 7, lat);
        check("lat_1x1", 64'(lat), 64'd5);
        const_mode = 1'b0;

        // Raster order across two rows.
        do_req(1, 10, 12, 20, 21, lat);
        check("lat_2x3", 64'(lat), 64'd20);

        // Backpressure on the second pixel.
        rdy_mode = 2;
        ready_manual = 1'b1;
        base = n_accept;
        fork
            do_req(1, 30, 33, 40, 40, lat);
            begin
                for (int t = 0; t < 200 && n_accept - base < 1; t++) @(negedge clock);
                ready_manual = 1'b0;
                repeat (6) @(negedge clock);
                ready_manual = 1'b1;
            end
        join
        check("lat_bp_stalled", 64'(lat > 14), 64'd1);
        rdy_mode = 0;

        // Rejected rectangle: X1 beyond the panel.
        do_req(0, 200, 240, 0, 5, lat);
        check("lat_reject", 64'(lat), 64'd2);

        // Randomized rectangles, including edge-of-panel and invalid ones.
        rdy_mode = 1;
        for (int it = 0; it < 24; it++) begin
            int idx, x0, x1, y0, y1, kind;
            idx = int'($urandom_range(0, N - 1));
            x0 = int'($urandom_range(0, W - 1));
            y0 = int'($urandom_range(0, H - 1));
            x1 = x0 + int'($urandom_range(0, 3));
            y1 = y0 + int'($urandom_range(0, 2));
            if (x1 > W - 1) x1 = W - 1;
            if (y1 > H - 1) y1 = H - 1;
            kind = int'($urandom_range(0, 7));
            if (kind == 0 && x0 > 0) x1 = x0 - 1;
            if (kind == 1 && y0 > 0) y1 = y0 - 1;
            if (kind == 2) x1 = W + int'($urandom_range(0, 15));
            if (kind == 3) y1 = H + int'($urandom_range(0, 191));
            if (kind == 4) begin x0 = W - 2; x1 = W - 1; y0 = H - 1; y1 = H - 1; end
            do_req(idx, x0, x1, y0, y1, lat);
        end
        rdy_mode = 0;

        // Reset during pixel 100 of a full-frame request.
        exp_grant.push_back(0);
        for (int i = 0; i < 150; i++)
            exp_px.push_back('{x: i % W, y: i / W, d: pix_fn(0, 8'(i % W), 9'(i / W))});
        set_rect(0, 0, W - 1, 0, H - 1);
        base = n_accept;
        reqValid[0] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            if (grant[0]) begin got = 1'b1; break; end
        end
        reqValid[0] = 1'b0;
        if (!got) fail_now("frame_grant_timeout");
        got = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clock);
            if (n_accept - base >= 99) begin got = 1'b1; break; end
        end
        if (!got) fail_now("frame_progress_timeout");
        apply_reset();
        check("frame_accepts_before_reset", 64'(n_accept - base), 64'd99);
        repeat (10) @(negedge clock);
        do_req(0, 0, 2, 0, 1, lat);

        // Contention from reset; each requester re-asserts after its done.
        apply_reset();
        set_rect(0, 1, 2, 1, 1);
        set_rect(1, 3, 3, 5, 6);
        order[0] = model_winner('1, model_ptr);
        order[1] = 1 - order[0];
        order[2] = order[0];
        order[3] = order[1];
        for (int i = 0; i < 4; i++) begin
            if (order[i] == 0) push_expect(0, 1, 2, 1, 1);
            else               push_expect(1, 3, 3, 5, 6);
        end
        cnt[0] = 0; cnt[1] = 0;
        reqValid = '1;
        for (int t = 0; t < 400 && !(cnt[0] == 2 && cnt[1] == 2); t++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (reqDone[i]) begin cnt[i]++; reqValid[i] = 1'b0; end
                else if (cnt[i] < 2) reqValid[i] = 1'b1;
            end
        end
        reqValid = '0;
        check("contention_done0", 64'(cnt[0]), 64'd2);
        check("contention_done1", 64'(cnt[1]), 64'd2);
        drain_check();
        check("grant_queue_empty", 64'(exp_grant.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
